// File: rtl/sram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter_if
// Purpose  : Requester-side bus of the SRAM port arbiter: two request
//            channels (valid/ready, byte enables, address, write data) and
//            the tagged response returned one cycle after acceptance.
// Revision : 1.0  initial release
// ============================================================================
interface sram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [1:0]              req_valid;
    logic [1:0]              req_ready;
    logic [7:0]              req_we;
    logic [2*ADDR_WIDTH-1:0] req_addr;
    logic [63:0]             req_wdata;
    logic [1:0]              rsp_valid;
    logic [31:0]             rsp_rdata;

    // Requester view: drives requests, observes ready and responses
    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    // Arbiter view
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter
// Purpose  : Round-robin sharing of one 32-bit byte-write SRAM port between
//            two requesters, with responses tagged to the issuing requester
//            one cycle after acceptance. When SRAM_ARB_CLEAR_EN is defined a
//            sweep engine can overwrite the whole memory with CLEAR_VALUE,
//            stalling both requesters while it runs.
// Options  : `define SRAM_ARB_CLEAR_EN  -> clear sweep engine present
// Revision : 1.0  initial release
// ============================================================================
module sram_port_arbiter #(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] CLEAR_VALUE = 32'h0000_0000
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    sram_port_arbiter_if.slave         bus,
    input  wire logic                  clear_start,
    output logic                       clear_busy,
    output logic                       clear_done,
    output logic                       mem_en,
    output logic [3:0]                 mem_we,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic [31:0]                mem_din,
    input  wire logic [31:0]           mem_dout
);

    logic                  r_last_grant;   // 1: requester 1 was granted last
    logic [1:0]            r_rsp_tag;      // one-hot owner of the response in flight
    logic [1:0]            w_grant;
    logic                  w_in_clear;
    logic [ADDR_WIDTH-1:0] w_sweep_addr;

`ifdef SRAM_ARB_CLEAR_EN
    localparam logic [0:0] c_ST_ARB   = 1'b0;
    localparam logic [0:0] c_ST_CLEAR = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] c_CNT_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_sweep_cnt;
    logic                  r_clear_done;

    // Sweep FSM: start only from ARB, walk every address once, pulse done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_ARB;
            r_sweep_cnt  <= '0;
            r_clear_done <= 1'b0;
        end else begin
            r_clear_done <= 1'b0;
            case (r_state)
                c_ST_ARB: begin
                    if (clear_start) begin
                        r_state <= c_ST_CLEAR;
                    end
                end
                c_ST_CLEAR: begin
                    // Counter naturally wraps to 0 after the last address
                    r_sweep_cnt <= r_sweep_cnt + c_CNT_ONE;
                    if (&r_sweep_cnt) begin
                        r_state      <= c_ST_ARB;
                        r_clear_done <= 1'b1;
                    end
                end
                default: r_state <= c_ST_ARB;
            endcase
        end
    end

    assign w_in_clear   = (r_state == c_ST_CLEAR);
    assign w_sweep_addr = r_sweep_cnt;
    assign clear_busy   = w_in_clear;
    assign clear_done   = r_clear_done;
`else
    logic w_unused_clear_start;

    assign w_unused_clear_start = clear_start;
    assign w_in_clear           = 1'b0;
    assign w_sweep_addr         = '0;
    assign clear_busy           = 1'b0;
    assign clear_done           = 1'b0;
`endif

    // Round-robin grant; reset and the sweep both block acceptance
    always_comb begin
        w_grant = 2'b00;
        if (!w_in_clear && !rst) begin
            case (bus.req_valid)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
                default: w_grant = 2'b00;
            endcase
        end
    end

    // SRAM port mux: sweep write, granted requester, or idle (all zero)
    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 4'h0;
        mem_addr = '0;
        mem_din  = 32'h0;
        if (w_in_clear) begin
            mem_en   = 1'b1;
            mem_we   = 4'hF;
            mem_addr = w_sweep_addr;
            mem_din  = CLEAR_VALUE;
        end else if (w_grant[1]) begin
            mem_en   = 1'b1;
            mem_we   = bus.req_we[7:4];
            mem_addr = bus.req_addr[ADDR_WIDTH +: ADDR_WIDTH];
            mem_din  = bus.req_wdata[63:32];
        end else if (w_grant[0]) begin
            mem_en   = 1'b1;
            mem_we   = bus.req_we[3:0];
            mem_addr = bus.req_addr[0 +: ADDR_WIDTH];
            mem_din  = bus.req_wdata[31:0];
        end
    end

    // Fairness pointer and response tag; tag aligns with the SRAM read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_rsp_tag    <= 2'b00;
        end else begin
            r_rsp_tag <= w_grant;
            if (w_grant != 2'b00) begin
                r_last_grant <= w_grant[1];
            end
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.rsp_valid = r_rsp_tag;
    assign bus.rsp_rdata = mem_dout;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_port_arbiter
// Purpose  : Self-checking bench for sram_port_arbiter (ADDR_WIDTH=4) with a
//            behavioural SRAM and a transaction-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_sram_port_arbiter;

    localparam int          AW    = 4;
    localparam int          DEPTH = 16;
    localparam logic [31:0] CV    = 32'hC1EA_C1EA;
`ifdef SRAM_ARB_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear_start = 1'b0;
    logic        clear_busy, clear_done;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout = 32'h0;

    sram_port_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    sram_port_arbiter #(.ADDR_WIDTH(AW), .CLEAR_VALUE(CV)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_dout    (mem_dout)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: registered read, read-before-write, byte enables
    logic [31:0] sram [DEPTH] = '{default: 32'h5A5A_5A5A};
    always @(posedge clk) begin
        if (mem_en) begin
            mem_dout <= sram[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
        end
    end

    // Reference model state (transaction level)
    logic [31:0] ref_mem [DEPTH] = '{default: 32'h5A5A_5A5A};
    bit          ref_last  = 1'b1;   // requester granted last
    int          ref_left  = 0;      // sweep words still to write
    bit          ref_done  = 1'b0;
    logic [1:0]  ref_tag   = 2'b00;
    logic [31:0] ref_rdata = 32'h0;
    logic [1:0]  last_g    = 2'b00;  // model's grant of the previous cycle

    int n_tests = 0;
    int n_fail  = 0;
    int busy_n, done_n;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] we,
                           input logic [3:0] a, input logic [31:0] d);
        if (i == 0) begin
            bus.req_valid[0]    = v;
            bus.req_we[3:0]     = we;
            bus.req_addr[3:0]   = a;
            bus.req_wdata[31:0] = d;
        end else begin
            bus.req_valid[1]     = v;
            bus.req_we[7:4]      = we;
            bus.req_addr[7:4]    = a;
            bus.req_wdata[63:32] = d;
        end
    endtask

    task automatic rnd_req(input int i);
        logic       v;
        logic [3:0] we;
        v  = ($urandom_range(0, 3) != 0);
        we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        set_req(i, v, we, 4'($urandom_range(0, 15)), $urandom);
    endtask

    // One clock: check outputs at negedge against the model, advance model
    task automatic cycle();
        logic [1:0]  g;
        logic        sel;
        int          a;
        logic [3:0]  we;
        logic [31:0] wd;
        @(negedge clk);
        g = 2'b00;
        if (ref_left == 0) begin
            if (bus.req_valid == 2'b11) g = ref_last ? 2'b10 ^ 2'b11 : 2'b10;
            else                        g = bus.req_valid;
        end
        chk("req_ready", bus.req_ready, g);
        chk("rsp_valid", bus.rsp_valid, ref_tag);
        if (ref_tag != 2'b00) chk("rsp_rdata", bus.rsp_rdata, ref_rdata);
        chk("clear_busy", clear_busy, (ref_left > 0));
        chk("clear_done", clear_done, ref_done);
        chk("mem_en", mem_en, (g != 2'b00) || (ref_left > 0));
        ref_tag  = g;
        ref_done = 1'b0;
        if (ref_left > 0) begin
            chk("sweep_addr", mem_addr, DEPTH - ref_left);
            chk("sweep_we", mem_we, 4'hF);
            chk("sweep_din", mem_din, CV);
            ref_mem[DEPTH - ref_left] = CV;
            ref_left--;
            ref_done = (ref_left == 0);
        end else begin
            if (g != 2'b00) begin
                sel = g[1];
                a   = sel ? int'(bus.req_addr[7:4]) : int'(bus.req_addr[3:0]);
                we  = sel ? bus.req_we[7:4] : bus.req_we[3:0];
                wd  = sel ? bus.req_wdata[63:32] : bus.req_wdata[31:0];
                chk("mem_addr", mem_addr, a);
                chk("mem_we", mem_we, we);
                chk("mem_din", mem_din, wd);
                ref_rdata = ref_mem[a];
                for (int b = 0; b < 4; b++)
                    if (we[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
                ref_last = sel;
            end else begin
                chk("idle_we", mem_we, 4'h0);
            end
            if (CLR_EN && clear_start) ref_left = DEPTH;
        end
        last_g = g;
        @(posedge clk);
        #1;
    endtask

    // Assert reset mid-cycle, check every output immediately, release after an edge
    task automatic do_reset();
        rst = 1'b1;
        clear_start = 1'b0;
        #1;
        chk("rst_req_ready", bus.req_ready, 2'b00);
        chk("rst_rsp_valid", bus.rsp_valid, 2'b00);
        chk("rst_clear_busy", clear_busy, 1'b0);
        chk("rst_clear_done", clear_done, 1'b0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_we", mem_we, 4'h0);
        chk("rst_mem_addr", mem_addr, 4'h0);
        chk("rst_mem_din", mem_din, 32'h0);
        ref_last = 1'b1;
        ref_left = 0;
        ref_done = 1'b0;
        ref_tag  = 2'b00;
        last_g   = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] contend_rsp [4];
        contend_rsp = '{2'b01, 2'b10, 2'b01, 2'b10};

        // Reset with both requesters already valid: outputs must stay quiet
        set_req(0, 1'b1, 4'h0, 4'd0, 32'h0);
        set_req(1, 1'b1, 4'h0, 4'd1, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // Contention straight after reset: grants 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("contend_rsp", bus.rsp_valid, contend_rsp[k]);
        end
        set_req(0, 1'b0, 4'h0, 4'd0, 32'h0);
        set_req(1, 1'b0, 4'h0, 4'd0, 32'h0);
        cycle();

        // Single requester write then read-back
        set_req(0, 1'b1, 4'hF, 4'd3, 32'hDEAD_BEEF);
        cycle();
        set_req(0, 1'b1, 4'h0, 4'd3, 32'h0);
        cycle();
        chk("rd_tag", bus.rsp_valid, 2'b01);
        chk("rd_data", bus.rsp_rdata, 32'hDEAD_BEEF);
        set_req(0, 1'b0, 4'h0, 4'd0, 32'h0);
        cycle();

        // Byte write on requester 1 over a preloaded word
        set_req(1, 1'b1, 4'hF, 4'd5, 32'h1122_3344);
        cycle();
        set_req(1, 1'b1, 4'b0010, 4'd5, 32'h0000_AA00);
        cycle();
        set_req(1, 1'b1, 4'h0, 4'd5, 32'h0);
        cycle();
        chk("byte_tag", bus.rsp_valid, 2'b10);
        chk("byte_data", bus.rsp_rdata, 32'h1122_AA44);
        set_req(1, 1'b0, 4'h0, 4'd0, 32'h0);
        cycle();

        // Clear sweep with requester 0 continuously reading address 3
        set_req(0, 1'b1, 4'h0, 4'd3, 32'h0);
        clear_start = 1'b1;
        cycle();
        clear_start = 1'b0;
        busy_n = 0;
        done_n = 0;
        for (int k = 0; k < 20; k++) begin
            busy_n += int'(clear_busy);
            done_n += int'(clear_done);
            cycle();
        end
        chk("clr_busy_cycles", busy_n, CLR_EN ? 16 : 0);
        chk("clr_done_pulses", done_n, CLR_EN ? 1 : 0);
        set_req(0, 1'b0, 4'h0, 4'd0, 32'h0);
        cycle();

        // Second clear_start mid-sweep is ignored
        clear_start = 1'b1;
        cycle();
        busy_n = 0;
        done_n = 0;
        for (int k = 0; k < 20; k++) begin
            clear_start = (k == 3);
            busy_n += int'(clear_busy);
            done_n += int'(clear_done);
            cycle();
        end
        clear_start = 1'b0;
        chk("rep_busy_cycles", busy_n, CLR_EN ? 16 : 0);
        chk("rep_done_pulses", done_n, CLR_EN ? 1 : 0);

        // Fill memory, start a sweep, reset at sweep cycle 7, read everything back
        for (int a = 0; a < DEPTH; a++) begin
            set_req(1, 1'b1, 4'hF, 4'(a), $urandom | 32'h1);
            cycle();
        end
        set_req(1, 1'b0, 4'h0, 4'd0, 32'h0);
        clear_start = 1'b1;
        cycle();
        clear_start = 1'b0;
        for (int k = 0; k < 7; k++) cycle();
        do_reset();
        for (int a = 0; a < DEPTH; a++) begin
            set_req(0, 1'b1, 4'h0, 4'(a), 32'h0);
            cycle();
        end

        // Reset with a response pending drops it
        set_req(0, 1'b1, 4'h0, 4'd9, 32'h0);
        cycle();
        set_req(0, 1'b0, 4'h0, 4'd0, 32'h0);
        do_reset();
        cycle();

        // Randomised traffic with occasional sweeps
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++)
                if (last_g[i] || !bus.req_valid[i]) rnd_req(i);
            clear_start = ($urandom_range(0, 80) == 0);
            cycle();
        end
        clear_start = 1'b0;
        set_req(0, 1'b0, 4'h0, 4'd0, 32'h0);
        set_req(1, 1'b0, 4'h0, 4'd0, 32'h0);
        for (int k = 0; k < 20; k++) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Run-time bound
    initial begin
        #500000;
        $display("FAIL timeout tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one port of the team's dual-port 32-bit byte-write SRAM between two requesters.
- Requesters get round-robin access through a valid/ready handshake.
- Read data is returned one cycle after acceptance, tagged to the requester that issued it.
- An optional sweep engine clears the whole memory to a programmable word; requesters are stalled while it runs.

Parameters:
- ADDR_WIDTH, 10, SRAM word-address width; must match the attached SRAM (depth 2**ADDR_WIDTH).
- CLEAR_VALUE, 32'h0000_0000, word written to every location by the clear sweep.

Ports:
- clk  input  1  single clock; all logic is posedge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  2  request valid, bit i = requester i.
- req_ready  output  2  request accepted this cycle (one-hot or zero).
- req_we  input  8  byte write enables; [4i+3:4i] belong to requester i; all-zero means read.
- req_addr  input  2*ADDR_WIDTH  word address; slice i belongs to requester i.
- req_wdata  input  64  write data; [32i+31:32i] belongs to requester i.
- rsp_valid  output  2  one-cycle pulse, bit i means the response belongs to requester i.
- rsp_rdata  output  32  read data, valid while any rsp_valid bit is high (connected directly to mem_dout).
- clear_start  input  1  single-cycle pulse that starts the clear sweep.
- clear_busy  output  1  high while the sweep runs.
- clear_done  output  1  one-cycle pulse when the sweep completes.
- mem_en  output  1  SRAM port enable.
- mem_we  output  4  SRAM byte write enables.
- mem_addr  output  ADDR_WIDTH  SRAM address.
- mem_din  output  32  SRAM write data.
- mem_dout  input  32  SRAM read data (registered inside the SRAM, 1-cycle latency, read-before-write).

Behaviour:
- Reset values:
  - req_ready=0, rsp_valid=0, clear_busy=0, clear_done=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_din=0.
  - Internal state: state=ARB, last_grant=1 (so requester 0 wins the first contention), sweep counter=0, response tag=none.
- States: ARB and CLEAR.
- ARB, grant logic (combinational):
  - Exactly one valid → grant it.
  - Both valid → grant the requester that is not last_grant.
  - None valid → no grant.
- ARB, granted cycle (combinational):
  - req_ready[g]=1.
  - mem_en=1, and mem_we/mem_addr/mem_din are the slices of requester g.
- ARB, non-granted cycle: mem_en=0 and mem_we=0.
- last_grant updates only on a grant.
- Responses:
  - Every accepted transfer, read or write, produces rsp_valid[g]=1 exactly one cycle later.
  - rsp_rdata=mem_dout. For a write this is the pre-write word.
  - Back-to-back grants give back-to-back responses with no bubble.
- ARB→CLEAR:
  - clear_start=1 in ARB moves to CLEAR on the next edge.
  - Arbitration in the start cycle itself still proceeds normally.
- CLEAR:
  - req_ready=0; clear_busy=1 from the first sweep cycle.
  - Each cycle: mem_en=1, mem_we=4'hF, mem_din=CLEAR_VALUE, mem_addr=counter; the counter increments.
  - The sweep takes exactly 2**ADDR_WIDTH cycles, addresses 0..2**ADDR_WIDTH-1.
  - The counter wraps to 0 after the last address.
  - No rsp_valid is generated for sweep writes. A response pending from the start cycle still emits in the first CLEAR cycle.
- CLEAR→ARB:
  - After the last-address cycle: clear_done=1 for one cycle, clear_busy=0 in that same cycle, and arbitration resumes in that same cycle.
- clear_start while clear_busy=1 is ignored.
- last_grant is preserved across a sweep.
- Reset mid-sweep aborts immediately. Memory stays partially cleared and clear_done is not pulsed.
- Reset with a response pending drops that response.
- Requesters must hold valid/we/addr/wdata stable until ready. The arbiter does not check this.

Optional Feature:
- SRAM_ARB_CLEAR_EN defined: the CLEAR state and sweep counter exist as described above.
- Not defined:
  - No CLEAR state and no counter.
  - clear_start is ignored; clear_busy and clear_done are tied 0.
  - The block is pure round-robin arbitration plus response tagging.

Test Plan (ADDR_WIDTH=4):
- Single requester: req0 writes we=4'hF, addr 3, 32'hDEADBEEF. Then req0 reads addr 3 → req_ready[0] in each request cycle; rsp_valid[0] one cycle after the read; rsp_rdata=32'hDEADBEEF.
- Contention: both valid for 4 cycles straight after reset → grants alternate 0,1,0,1. rsp_valid pulses follow one cycle later as 01,10,01,10 (binary).
- Byte write: mem preloaded 32'h11223344; req1 writes we=4'b0010, data 32'hxxxxAAxx to addr 5; then reads addr 5 → rsp_rdata=32'h1122AA44 on rsp_valid[1].
- Clear: clear_start pulse → clear_busy high for 16 cycles, mem_addr steps 0..15, mem_we=4'hF. A req0 held valid throughout sees ready=0 until the clear_done cycle; reads then return CLEAR_VALUE.
- Reset at sweep cycle 7: rst pulse → all outputs return to reset values, no clear_done. Addresses 0..6 are cleared and 7..15 keep their old data.
- clear_start repeated at sweep cycle 3 → ignored; the sweep still lasts exactly 16 cycles with a single clear_done.
